// File: rtl/spm_boot_ctrl.sv
// Boot/run controller for RISC_SPM: clears SRAM, streams an image into it, releases
// the processor and watches for HALT or a run-cycle timeout.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start; processor held in reset
// S_CLEAR   | writing zero to every SRAM address, one per cycle
// S_LOAD    | accepting image beats, each written one cycle after acceptance
// S_SETTLE  | final image write in flight; processor still in reset
// S_RUN     | processor running; counting cycles, watching IR for HALT
// S_HALTED  | HALT seen; processor left out of reset so its state is visible
// S_TIMEOUT | run budget exhausted; processor back in reset
module spm_boot_ctrl #(
  parameter int         WORD_SIZE   = 8,
  parameter int         ADDR_SIZE   = 8,
  parameter logic [3:0] HALT_OPCODE = 4'b1111,
  parameter int         TIMEOUT     = 1400,
  parameter int         CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 load_valid,
  input  logic [ADDR_SIZE-1:0] load_addr,
  input  logic [WORD_SIZE-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_rst_n,
  input  logic [WORD_SIZE-1:0] cpu_ir,
  input  logic                 cpu_ir_load,
  output logic                 busy,
  output logic                 halted,
  output logic                 timed_out,
  output logic [CNT_W-1:0]     run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SETTLE, S_RUN, S_HALTED, S_TIMEOUT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t                 state, state_nxt;
  logic                   we_nxt;
  logic [ADDR_SIZE-1:0]   addr_nxt;
  logic [WORD_SIZE-1:0]   wdata_nxt;
  logic [CNT_W-1:0]       cyc_nxt;
  logic                   rst_n_nxt;
  logic                   busy_nxt;
  logic                   halted_nxt;
  logic                   timed_out_nxt;
  logic                   halt_seen;
  logic                   ir_unused;

  assign halt_seen = cpu_ir_load && (cpu_ir[WORD_SIZE-1 -: 4] == HALT_OPCODE);
  assign ir_unused = ^cpu_ir[WORD_SIZE-5:0];

  // Decoded from the state register only, so it carries no input-to-output path.
  assign load_ready = (state == S_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      timed_out  <= 1'b0;
      run_cycles <= '0;
    end else begin
      state      <= state_nxt;
      mem_we     <= we_nxt;
      mem_addr   <= addr_nxt;
      mem_wdata  <= wdata_nxt;
      cpu_rst_n  <= rst_n_nxt;
      busy       <= busy_nxt;
      halted     <= halted_nxt;
      timed_out  <= timed_out_nxt;
      run_cycles <= cyc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    cyc_nxt   = run_cycles;

    case (state)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (start) begin
          state_nxt = S_CLEAR;
          we_nxt    = 1'b1;
          addr_nxt  = '0;
          wdata_nxt = '0;
          cyc_nxt   = '0;
        end
      end
      // mem_addr doubles as the clear counter; the last address ends the sweep.
      S_CLEAR: begin
        if (mem_addr == '1) begin
          state_nxt = S_LOAD;
        end else begin
          we_nxt    = 1'b1;
          addr_nxt  = mem_addr + ADDR_SIZE'(1);
          wdata_nxt = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          we_nxt    = 1'b1;
          addr_nxt  = load_addr;
          wdata_nxt = load_data;
          if (load_last) state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: state_nxt = S_RUN;
      S_RUN: begin
        cyc_nxt = run_cycles + CNT_W'(1);
        if (halt_seen)                     state_nxt = S_HALTED;
        else if (cyc_nxt == TIMEOUT_CNT)   state_nxt = S_TIMEOUT;
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt      = (state_nxt == S_CLEAR) || (state_nxt == S_LOAD) ||
                    (state_nxt == S_SETTLE) || (state_nxt == S_RUN);
    rst_n_nxt     = (state_nxt == S_RUN) || (state_nxt == S_HALTED);
    halted_nxt    = (state_nxt == S_HALTED);
    timed_out_nxt = (state_nxt == S_TIMEOUT);
  end

endmodule
